decode_cond_ctrl: RTL and testbench

- Decode-stage control block for the 5-stage ARM-subset pipeline.
- Decodes the IF/ID instruction into control signals, zeroes them when a hazard stall is requested, and holds the PSR flag register.
- Evaluates the condition field against the selected flags and produces the Branch and BranchL redirect signals for IF and for the RD-select logic.

---
 rtl/decode_pkg.sv | 73 +++++++
 rtl/decode_cond_ctrl_cond_eval.sv | 39 +++
 rtl/decode_cond_ctrl.sv | 132 +++++++++++++
 tb/tb_decode_cond_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: addressing modes, ALU opcodes, condition codes,
// flag bit positions and the decoded-control bundle.
package decode_pkg;

  // Shifter addressing modes
  localparam logic [1:0] AM_IMM32 = 2'b00;
  localparam logic [1:0] AM_REG   = 2'b01;
  localparam logic [1:0] AM_IMM12 = 2'b10;
  localparam logic [1:0] AM_SHIFT = 2'b11;

  // ALU opcodes used for load/store address generation
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  // Instruction classes on instruction[27:25]
  localparam logic [2:0] CLS_DP_REG = 3'b000;
  localparam logic [2:0] CLS_DP_IMM = 3'b001;
  localparam logic [2:0] CLS_LS_IMM = 3'b010;
  localparam logic [2:0] CLS_LS_REG = 3'b011;
  localparam logic [2:0] CLS_BRANCH = 3'b101;

  // Flag bit indices within {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  // Decoded control bundle as seen by the ID/EX register
  typedef struct packed {
    logic [3:0] opcode;
    logic [1:0] am;
    logic       s_enable;
    logic       load_instr;
    logic       rf_enable;
    logic       size_enable;
    logic       rw_enable;
    logic       enable_signal;
    logic       bl_instr;
    logic       b_instr;
  } ctrl_t;

  // Three-letter data-processing mnemonic, used by the debug keyword output
  function automatic logic [23:0] dp_mnemonic(input logic [3:0] op);
    logic [23:0] m;
    case (op)
      4'h0:    m = "AND";
      4'h1:    m = "EOR";
      4'h2:    m = "SUB";
      4'h3:    m = "RSB";
      4'h4:    m = "ADD";
      4'h5:    m = "ADC";
      4'h6:    m = "SBC";
      4'h7:    m = "RSC";
      4'h8:    m = "TST";
      4'h9:    m = "TEQ";
      4'hA:    m = "CMP";
      4'hB:    m = "CMN";
      4'hC:    m = "ORR";
      4'hD:    m = "MOV";
      4'hE:    m = "BIC";
      default: m = "MVN";
    endcase
    return m;
  endfunction

endpackage

// File: rtl/decode_cond_ctrl_cond_eval.sv
// Condition-field evaluator: ARM cond[3:0] against {N,Z,C,V}.
module cond_eval
  import decode_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_true
);

  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Standard ARM condition table; NV never executes
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_EQ: cond_true = z;
      COND_NE: cond_true = ~z;
      COND_CS: cond_true = c;
      COND_CC: cond_true = ~c;
      COND_MI: cond_true = n;
      COND_PL: cond_true = ~n;
      COND_VS: cond_true = v;
      COND_VC: cond_true = ~v;
      COND_HI: cond_true = c & ~z;
      COND_LS: cond_true = ~c | z;
      COND_GE: cond_true = (n == v);
      COND_LT: cond_true = (n != v);
      COND_GT: cond_true = ~z & (n == v);
      COND_LE: cond_true = z | (n != v);
      COND_AL: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_cond_ctrl.sv
// Decode-stage control: instruction decode, stall bubble mux, PSR flag
// register and branch/branch-with-link redirect generation.
// Optional: define DECODE_KEYWORD_EN to add a 48-bit ASCII mnemonic output
// of the pre-stall decode for debug/trace.
module decode_cond_ctrl
  import decode_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        R,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        ex_s_enable,
  input  logic [3:0]  alu_nzcv,
  output logic [3:0]  id_opcode,
  output logic [1:0]  id_am,
  output logic        id_s_enable,
  output logic        id_load_instr,
  output logic        id_rf_enable,
  output logic        id_size_enable,
  output logic        id_rw_enable,
  output logic        id_enable_signal,
  output logic        id_bl_instr,
  output logic        id_b_instr,
  output logic [3:0]  psr_flags,
  output logic        cond_true,
  output logic        branch,
  output logic        branch_l
`ifdef DECODE_KEYWORD_EN
  ,
  output logic [47:0] keyword
`endif
);

  ctrl_t      dec;
  ctrl_t      ctrl;
  logic [3:0] psr_flags_d, psr_flags_q;
  logic [3:0] sel_flags;
  logic [2:0] cls;

  assign cls = instruction[27:25];

  // Combinational decode of the IF/ID instruction
  always_comb begin
    dec = '0;
    if (instruction != NOP_WORD) begin
      case (cls)
        CLS_DP_REG, CLS_DP_IMM: begin
          // Register-shifted-register form is not supported: leave as bubble
          if (!(cls == CLS_DP_REG && instruction[4])) begin
            dec.am        = (cls == CLS_DP_IMM) ? AM_IMM32 : AM_SHIFT;
            dec.opcode    = instruction[24:21];
            dec.s_enable  = instruction[20];
            // TST/TEQ/CMP/CMN only set flags, no register write-back
            dec.rf_enable = (instruction[24:23] != 2'b10);
          end
        end
        CLS_LS_IMM, CLS_LS_REG: begin
          dec.am            = (cls == CLS_LS_IMM) ? AM_IMM12 : AM_REG;
          dec.opcode        = instruction[23] ? ALU_ADD : ALU_SUB;
          dec.enable_signal = 1'b1;
          dec.size_enable   = ~instruction[22];
          dec.load_instr    = instruction[20];
          dec.rf_enable     = instruction[20];
          dec.rw_enable     = ~instruction[20];
        end
        CLS_BRANCH: begin
          dec.bl_instr = instruction[24];
          dec.b_instr  = ~instruction[24];
        end
        default: dec = '0;
      endcase
    end
  end

  // Hazard bubble: a stall zeroes every control going to ID/EX
  always_comb begin
    ctrl = stall ? '0 : dec;
  end

  assign id_opcode        = ctrl.opcode;
  assign id_am            = ctrl.am;
  assign id_s_enable      = ctrl.s_enable;
  assign id_load_instr    = ctrl.load_instr;
  assign id_rf_enable     = ctrl.rf_enable;
  assign id_size_enable   = ctrl.size_enable;
  assign id_rw_enable     = ctrl.rw_enable;
  assign id_enable_signal = ctrl.enable_signal;
  assign id_bl_instr      = ctrl.bl_instr;
  assign id_b_instr       = ctrl.b_instr;

  // Flags from a flag-setting op in EX are forwarded ahead of the PSR
  always_comb begin
    sel_flags   = ex_s_enable ? alu_nzcv : psr_flags_q;
    psr_flags_d = ex_s_enable ? alu_nzcv : psr_flags_q;
  end

  // PSR flag register, cleared asynchronously
  always_ff @(posedge clk or negedge R) begin
    if (!R) psr_flags_q <= '0;
    else    psr_flags_q <= psr_flags_d;
  end

  assign psr_flags = psr_flags_q;

  cond_eval u_cond_eval (
    .cond      (instruction[31:28]),
    .flags     (sel_flags),
    .cond_true (cond_true)
  );

  // Redirects use post-stall controls so a bubbled branch never fires
  assign branch   = cond_true & (ctrl.b_instr | ctrl.bl_instr);
  assign branch_l = cond_true & ctrl.bl_instr;

`ifdef DECODE_KEYWORD_EN
  // Space-padded mnemonic of the pre-stall decode
  always_comb begin
    keyword = "NOP   ";
    if (dec.bl_instr)
      keyword = "BL    ";
    else if (dec.b_instr)
      keyword = "B     ";
    else if (dec.enable_signal)
      keyword = {(dec.load_instr ? "LDR" : "STR"), (dec.size_enable ? " " : "B"), "  "};
    else if (dec != '0)
      keyword = {dp_mnemonic(dec.opcode), (dec.s_enable ? "S" : " "), "  "};
  end
`endif

endmodule

// File: tb/tb_decode_cond_ctrl.sv
// Self-checking bench for decode_cond_ctrl: directed scenarios plus a
// randomized run against a behavioural model of decode, conditions and PSR.
module tb_decode_cond_ctrl;

  logic        clk = 1'b0;
  logic        R;
  logic [31:0] instruction;
  logic        stall;
  logic        ex_s_enable;
  logic [3:0]  alu_nzcv;
  logic [3:0]  id_opcode;
  logic [1:0]  id_am;
  logic        id_s_enable, id_load_instr, id_rf_enable, id_size_enable;
  logic        id_rw_enable, id_enable_signal, id_bl_instr, id_b_instr;
  logic [3:0]  psr_flags;
  logic        cond_true, branch, branch_l;
`ifdef DECODE_KEYWORD_EN
  logic [47:0] keyword;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] mpsr;

  decode_cond_ctrl dut (
    .clk(clk), .R(R), .instruction(instruction), .stall(stall),
    .ex_s_enable(ex_s_enable), .alu_nzcv(alu_nzcv),
    .id_opcode(id_opcode), .id_am(id_am), .id_s_enable(id_s_enable),
    .id_load_instr(id_load_instr), .id_rf_enable(id_rf_enable),
    .id_size_enable(id_size_enable), .id_rw_enable(id_rw_enable),
    .id_enable_signal(id_enable_signal), .id_bl_instr(id_bl_instr),
    .id_b_instr(id_b_instr), .psr_flags(psr_flags), .cond_true(cond_true),
    .branch(branch), .branch_l(branch_l)
`ifdef DECODE_KEYWORD_EN
    , .keyword(keyword)
`endif
  );

  always #5 clk = ~clk;

  // {opcode, am, s, load, rf, size, rw, en, bl, b}
  function automatic logic [13:0] got_ctrl();
    return {id_opcode, id_am, id_s_enable, id_load_instr, id_rf_enable,
            id_size_enable, id_rw_enable, id_enable_signal, id_bl_instr, id_b_instr};
  endfunction

  // Reference decode following the instruction-class rules
  function automatic logic [13:0] model_ctrl(input logic [31:0] ins, input logic stl);
    logic [3:0] op = 0; logic [1:0] am = 0;
    logic s = 0, ld = 0, rf = 0, sz = 0, rw = 0, en = 0, bl = 0, b = 0;
    int cls = int'(ins[27:25]);
    if (stl || ins == 32'h0) return 14'h0;
    if (cls == 0 || cls == 1) begin
      if (cls == 0 && ins[4]) return 14'h0;
      op = ins[24:21];
      am = (cls == 1) ? 2'd0 : 2'd3;
      s  = ins[20];
      rf = !(op >= 8 && op <= 11);
    end else if (cls == 2 || cls == 3) begin
      op = ins[23] ? 4'd4 : 4'd2;
      am = (cls == 2) ? 2'd2 : 2'd1;
      en = 1; sz = !ins[22]; ld = ins[20]; rf = ins[20]; rw = !ins[20];
    end else if (cls == 5) begin
      bl = ins[24]; b = !ins[24];
    end
    return {op, am, s, ld, rf, sz, rw, en, bl, b};
  endfunction

  // Conditions come in complementary pairs: evaluate the even member, invert for odd
  function automatic logic model_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n = f[3], z = f[2], c = f[1], v = f[0];
    logic base;
    int pair = int'(cond) / 2;
    if (cond == 4'd15) return 1'b0;
    case (pair)
      0: base = z;
      1: base = c;
      2: base = n;
      3: base = v;
      4: base = c && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (cond[0] && cond != 4'd14) ? !base : base;
  endfunction

  // Advance to the next cycle, accounting for the edge just passed, then drive
  task automatic apply(input logic [31:0] ins, input logic stl);
    @(negedge clk);
    if (!R) mpsr = 4'h0;
    else if (ex_s_enable) mpsr = alu_nzcv;
    instruction = ins;
    stall = stl;
    #1;
  endtask

  task automatic test_reset();
    R = 1'b0; ex_s_enable = 1'b1; alu_nzcv = 4'hF;
    apply(32'h0, 1'b0);
    n_cmp++;
    if (psr_flags !== 4'h0) begin
      n_bad++; $display("FAIL reset_psr got=%h exp=0", psr_flags);
    end
    n_cmp++;
    if (got_ctrl() !== 14'h0 || branch !== 1'b0 || branch_l !== 1'b0) begin
      n_bad++; $display("FAIL reset_nop_ctrl got=%h br=%b bl=%b exp=0", got_ctrl(), branch, branch_l);
    end
    ex_s_enable = 1'b0; alu_nzcv = 4'h0;
    R = 1'b1;
    apply(32'h0, 1'b0);
  endtask

  task automatic test_dp();
    apply(32'hE292_1004, 1'b0);  // ADDS r1,r2,#4
    n_cmp++;
    if (got_ctrl() !== {4'b0100, 2'b00, 8'b1010_0000}) begin
      n_bad++; $display("FAIL adds_imm got=%h exp=%h", got_ctrl(), {4'b0100, 2'b00, 8'b1010_0000});
    end
`ifdef DECODE_KEYWORD_EN
    n_cmp++;
    if (keyword !== "ADDS  ") begin
      n_bad++; $display("FAIL kw_adds got=%s exp=ADDS", keyword);
    end
`endif
    apply(32'hE151_0002, 1'b0);  // CMP r1,r2
    n_cmp++;
    if (id_rf_enable !== 1'b0 || id_opcode !== 4'b1010 || id_am !== 2'b11 || id_s_enable !== 1'b1) begin
      n_bad++; $display("FAIL cmp_reg got=%h", got_ctrl());
    end
    apply(32'hE081_2013, 1'b0);  // register-shifted-register form -> NOP
    n_cmp++;
    if (got_ctrl() !== 14'h0) begin
      n_bad++; $display("FAIL rsr_nop got=%h exp=0", got_ctrl());
    end
  endtask

  task automatic test_ls();
    apply(32'hE5D0_1003, 1'b0);  // LDRB r1,[r0,#3]
    n_cmp++;
    if (got_ctrl() !== {4'b0100, 2'b10, 8'b0110_0100}) begin
      n_bad++; $display("FAIL ldrb got=%h exp=%h", got_ctrl(), {4'b0100, 2'b10, 8'b0110_0100});
    end
    apply(32'hE5D0_1003, 1'b1);
    n_cmp++;
    if (got_ctrl() !== 14'h0) begin
      n_bad++; $display("FAIL ldrb_stall got=%h exp=0", got_ctrl());
    end
    apply(32'hE700_1002, 1'b0);  // STR r1,[r0,-r2] register form, U=0
    n_cmp++;
    if (got_ctrl() !== {4'b0010, 2'b01, 8'b0001_1100}) begin
      n_bad++; $display("FAIL str_reg got=%h exp=%h", got_ctrl(), {4'b0010, 2'b01, 8'b0001_1100});
    end
  endtask

  task automatic test_branch();
    ex_s_enable = 1'b1; alu_nzcv = 4'b0100;
    apply(32'h0A00_0000, 1'b0);  // BEQ
    n_cmp++;
    if (branch !== 1'b1 || branch_l !== 1'b0) begin
      n_bad++; $display("FAIL beq_taken br=%b bl=%b exp=1/0", branch, branch_l);
    end
    alu_nzcv = 4'b0000; #1;
    n_cmp++;
    if (branch !== 1'b0 || cond_true !== 1'b0) begin
      n_bad++; $display("FAIL beq_not_taken br=%b ct=%b exp=0/0", branch, cond_true);
    end
    ex_s_enable = 1'b0;
    apply(32'hEB00_0005, 1'b0);  // BL
    n_cmp++;
    if (branch !== 1'b1 || branch_l !== 1'b1 || id_bl_instr !== 1'b1) begin
      n_bad++; $display("FAIL bl_al br=%b bl=%b bli=%b exp=1/1/1", branch, branch_l, id_bl_instr);
    end
    apply(32'hEB00_0005, 1'b1);
    n_cmp++;
    if (branch !== 1'b0 || branch_l !== 1'b0) begin
      n_bad++; $display("FAIL bl_stall br=%b bl=%b exp=0/0", branch, branch_l);
    end
    apply(32'hFA00_0000, 1'b0);  // cond NV
    n_cmp++;
    if (branch !== 1'b0 || id_b_instr !== 1'b1) begin
      n_bad++; $display("FAIL b_never br=%b b=%b exp=0/1", branch, id_b_instr);
    end
  endtask

  task automatic test_psr();
    ex_s_enable = 1'b1; alu_nzcv = 4'b1010;
    apply(32'h0, 1'b0);
    ex_s_enable = 1'b0; alu_nzcv = 4'b0101;
    apply(32'h0, 1'b0);
    n_cmp++;
    if (psr_flags !== 4'b1010) begin
      n_bad++; $display("FAIL psr_load got=%b exp=1010", psr_flags);
    end
    apply(32'h0, 1'b0);
    n_cmp++;
    if (psr_flags !== 4'b1010) begin
      n_bad++; $display("FAIL psr_hold got=%b exp=1010", psr_flags);
    end
    #2 R = 1'b0;
    #1;
    n_cmp++;
    if (psr_flags !== 4'b0000) begin
      n_bad++; $display("FAIL psr_async_clr got=%b exp=0000", psr_flags);
    end
    apply(32'h0, 1'b0);
    R = 1'b1; ex_s_enable = 1'b1; alu_nzcv = 4'b0011;
    #1;
    n_cmp++;
    if (psr_flags !== 4'b0000) begin
      n_bad++; $display("FAIL psr_release got=%b exp=0000", psr_flags);
    end
    apply(32'h0, 1'b0);
    n_cmp++;
    if (psr_flags !== 4'b0011) begin
      n_bad++; $display("FAIL psr_first_edge got=%b exp=0011", psr_flags);
    end
    ex_s_enable = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [3:0]  fsel;
    logic [13:0] exp_c;
    logic        exp_t;
    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      case ($urandom_range(0, 7))
        0: ins[27:25] = 3'd0;
        1: ins[27:25] = 3'd1;
        2: ins[27:25] = 3'd2;
        3: ins[27:25] = 3'd3;
        4, 5: ins[27:25] = 3'd5;
        default: ;
      endcase
      if ($urandom_range(0, 19) == 0) ins = 32'h0;
      apply(ins, ($urandom_range(0, 3) == 0));
      ex_s_enable = $urandom_range(0, 1);
      alu_nzcv = 4'($urandom);
      #1;
      fsel  = ex_s_enable ? alu_nzcv : mpsr;
      exp_c = model_ctrl(instruction, stall);
      exp_t = model_cond(instruction[31:28], fsel);
      n_cmp++;
      if (got_ctrl() !== exp_c) begin
        n_bad++; $display("FAIL rnd_ctrl ins=%h st=%b got=%h exp=%h", instruction, stall, got_ctrl(), exp_c);
      end
      n_cmp++;
      if (cond_true !== exp_t) begin
        n_bad++; $display("FAIL rnd_cond ins=%h f=%b got=%b exp=%b", instruction, fsel, cond_true, exp_t);
      end
      n_cmp++;
      if (branch !== (exp_t & (exp_c[0] | exp_c[1])) || branch_l !== (exp_t & exp_c[1])) begin
        n_bad++; $display("FAIL rnd_branch ins=%h got=%b%b exp=%b%b", instruction, branch, branch_l,
                          exp_t & (exp_c[0] | exp_c[1]), exp_t & exp_c[1]);
      end
      n_cmp++;
      if (psr_flags !== mpsr) begin
        n_bad++; $display("FAIL rnd_psr got=%b exp=%b", psr_flags, mpsr);
      end
    end
  endtask

  initial begin
    R = 1'b0; instruction = 32'h0; stall = 1'b0;
    ex_s_enable = 1'b0; alu_nzcv = 4'h0; mpsr = 4'h0;
    test_reset();
    test_dp();
    test_ls();
    test_branch();
    test_psr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
